tx_sched_cmd_arb: RTL and testbench

Round-robin arbiter that shares the single TX scheduler command port among `NUM_SRC` requesters: the retransmit timeout engine, the RX ACK-pending engine and the app send path. Each requester presents a `sched_cmd_struct` with a val/rdy handshake. The winner is registered into a one-entry output stage that drives the TX scheduler. With an optional build feature, compatible commands to the same flow from different sources are merged into one scheduler write.

---
 rtl/tx_sched_cmd_arb.sv | 130 +++++++++++++
 tb/tb_tx_sched_cmd_arb.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tx_sched_cmd_arb.sv
// Round-robin arbiter sharing the TX scheduler command port among NUM_SRC requesters.
// Optional merging of compatible same-flow commands: define TX_SCHED_ARB_COALESCE_EN.

package tx_sched_cmd_arb_pkg;

  localparam logic [1:0] CMD_NOP   = 2'd0;
  localparam logic [1:0] CMD_SET   = 2'd1;
  localparam logic [1:0] CMD_CLEAR = 2'd2;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [15:0] timestamp;
  } pend_field_t;

  typedef struct packed {
    logic [15:0] flowid;
    pend_field_t ack_pend_set_clear;
    pend_field_t data_pend_set_clear;
    pend_field_t rt_pend_set_clear;
  } sched_cmd_struct;

endpackage

module tx_sched_cmd_arb
  import tx_sched_cmd_arb_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic            [NUM_SRC-1:0]        src_cmd_val,
  input  sched_cmd_struct [NUM_SRC-1:0]        src_cmd_data,
  output logic            [NUM_SRC-1:0]        src_cmd_rdy,
  output logic                                 arb_tx_sched_cmd_val,
  output sched_cmd_struct                      arb_tx_sched_cmd_data,
  input  logic                                 tx_sched_arb_cmd_rdy
);

  logic                 r_out_val;
  sched_cmd_struct      r_out_data;
  logic [SRC_W-1:0]     r_rr_ptr;

  logic                 w_load;
  logic                 w_found;
  int                   w_win_idx;
  int                   w_scan_idx;
  logic [NUM_SRC-1:0]   w_grant;
  sched_cmd_struct      w_acc;
  logic [SRC_W-1:0]     w_next_ptr;

`ifdef TX_SCHED_ARB_COALESCE_EN
  function automatic logic fieldFree(input pend_field_t a, input pend_field_t b);
    return (a.cmd == CMD_NOP) || (b.cmd == CMD_NOP);
  endfunction

  function automatic logic canMerge(input sched_cmd_struct acc, input sched_cmd_struct nxt);
    return (acc.flowid == nxt.flowid) &&
           fieldFree(acc.ack_pend_set_clear,  nxt.ack_pend_set_clear) &&
           fieldFree(acc.data_pend_set_clear, nxt.data_pend_set_clear) &&
           fieldFree(acc.rt_pend_set_clear,   nxt.rt_pend_set_clear);
  endfunction

  function automatic sched_cmd_struct mergeCmd(input sched_cmd_struct acc, input sched_cmd_struct nxt);
    sched_cmd_struct res;
    res = acc;
    if (acc.ack_pend_set_clear.cmd == CMD_NOP)  res.ack_pend_set_clear  = nxt.ack_pend_set_clear;
    if (acc.data_pend_set_clear.cmd == CMD_NOP) res.data_pend_set_clear = nxt.data_pend_set_clear;
    if (acc.rt_pend_set_clear.cmd == CMD_NOP)   res.rt_pend_set_clear   = nxt.rt_pend_set_clear;
    return res;
  endfunction
`endif

  assign w_load = ~r_out_val | tx_sched_arb_cmd_rdy;

  // Scan from the pointer; the first valid source wins, later ones may be merged into it.
  always_comb begin
    w_found    = 1'b0;
    w_win_idx  = 0;
    w_scan_idx = 0;
    w_grant    = '0;
    w_acc      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_scan_idx = int'(r_rr_ptr) + k;
      if (w_scan_idx >= NUM_SRC) w_scan_idx = w_scan_idx - NUM_SRC;
      if (src_cmd_val[w_scan_idx]) begin
        if (!w_found) begin
          w_found             = 1'b1;
          w_win_idx           = w_scan_idx;
          w_grant[w_scan_idx] = 1'b1;
          w_acc               = src_cmd_data[w_scan_idx];
        end
`ifdef TX_SCHED_ARB_COALESCE_EN
        else if (canMerge(w_acc, src_cmd_data[w_scan_idx])) begin
          w_grant[w_scan_idx] = 1'b1;
          w_acc               = mergeCmd(w_acc, src_cmd_data[w_scan_idx]);
        end
`endif
      end
    end
    if (!w_load) w_grant = '0;
  end

  always_comb begin
    w_next_ptr = '0;
    if (w_win_idx != NUM_SRC - 1) w_next_ptr = SRC_W'(w_win_idx + 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_val  <= 1'b0;
      r_out_data <= '0;
      r_rr_ptr   <= '0;
    end else if (w_load) begin
      if (w_found) begin
        r_out_val  <= 1'b1;
        r_out_data <= w_acc;
        r_rr_ptr   <= w_next_ptr;
      end else begin
        r_out_val  <= 1'b0;
      end
    end
  end

  // Reset gates the combinational accept so nothing is taken while the block is held.
  assign src_cmd_rdy           = w_grant & {NUM_SRC{rst_n}};
  assign arb_tx_sched_cmd_val  = r_out_val;
  assign arb_tx_sched_cmd_data = r_out_data;

endmodule

// File: tb/tb_tx_sched_cmd_arb.sv
// Directed, table-driven bench for tx_sched_cmd_arb (NUM_SRC=3); follows TX_SCHED_ARB_COALESCE_EN.
module tb_tx_sched_cmd_arb;
  import tx_sched_cmd_arb_pkg::*;

  typedef struct {
    logic [2:0]      val;
    sched_cmd_struct d0;
    sched_cmd_struct d1;
    sched_cmd_struct d2;
    logic            schedRdy;
    logic [2:0]      expRdy;
    logic            expVal;
    sched_cmd_struct expData;
  } vec_t;

  logic                  clk;
  logic                  rst_n;
  logic [2:0]            srcVal;
  sched_cmd_struct [2:0] srcData;
  logic [2:0]            srcRdy;
  logic                  outVal;
  sched_cmd_struct       outData;
  logic                  schedRdy;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  tx_sched_cmd_arb #(.NUM_SRC(3)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .src_cmd_val           (srcVal),
    .src_cmd_data          (srcData),
    .src_cmd_rdy           (srcRdy),
    .arb_tx_sched_cmd_val  (outVal),
    .arb_tx_sched_cmd_data (outData),
    .tx_sched_arb_cmd_rdy  (schedRdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic sched_cmd_struct mkCmd(input logic [15:0] flow,
                                            input logic [1:0] ackC, input logic [15:0] ackT,
                                            input logic [1:0] datC, input logic [15:0] datT,
                                            input logic [1:0] rtC,  input logic [15:0] rtT);
    sched_cmd_struct c;
    c.flowid                        = flow;
    c.ack_pend_set_clear.cmd        = ackC;
    c.ack_pend_set_clear.timestamp  = ackT;
    c.data_pend_set_clear.cmd       = datC;
    c.data_pend_set_clear.timestamp = datT;
    c.rt_pend_set_clear.cmd         = rtC;
    c.rt_pend_set_clear.timestamp   = rtT;
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic [2:0] val, input sched_cmd_struct d0,
                                 input sched_cmd_struct d1, input sched_cmd_struct d2,
                                 input logic sRdy, input logic [2:0] eRdy,
                                 input logic eVal, input sched_cmd_struct eData);
    vec_t v;
    v.val = val; v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.schedRdy = sRdy; v.expRdy = eRdy; v.expVal = eVal; v.expData = eData;
    return v;
  endfunction

  // Drive at the falling edge, check accepts mid-cycle, check the registered output after the rising edge.
  task automatic applyStimulus(input vec_t v, input int n);
    @(negedge clk);
    srcVal     = v.val;
    srcData[0] = v.d0;
    srcData[1] = v.d1;
    srcData[2] = v.d2;
    schedRdy   = v.schedRdy;
    #1;
    checkOutput($sformatf("vec%0d.src_rdy", n), 128'(srcRdy), 128'(v.expRdy));
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d.out_val", n), 128'(outVal), 128'(v.expVal));
    if (v.expVal)
      checkOutput($sformatf("vec%0d.out_data", n), 128'(outData), 128'(v.expData));
  endtask

  sched_cmd_struct z, cA, c0, c1, c2, m0, m1, mAll, dD, k0, k2, r0;

  initial begin
    z    = '0;
    cA   = mkCmd(16'd5,  CMD_NOP, 16'h0,  CMD_NOP, 16'h0,   CMD_SET,   16'h11);
    c0   = mkCmd(16'd10, CMD_NOP, 16'h0,  CMD_SET, 16'h100, CMD_NOP,   16'h0);
    c1   = mkCmd(16'd11, CMD_SET, 16'h101, CMD_NOP, 16'h0,  CMD_NOP,   16'h0);
    c2   = mkCmd(16'd12, CMD_NOP, 16'h0,  CMD_NOP, 16'h0,   CMD_CLEAR, 16'h102);
    m0   = mkCmd(16'd7,  CMD_NOP, 16'h0,  CMD_NOP, 16'h0,   CMD_SET,   16'h70);
    m1   = mkCmd(16'd7,  CMD_SET, 16'h71, CMD_NOP, 16'h0,   CMD_NOP,   16'h0);
    mAll = mkCmd(16'd7,  CMD_SET, 16'h71, CMD_NOP, 16'h0,   CMD_SET,   16'h70);
    dD   = mkCmd(16'd20, CMD_NOP, 16'h0,  CMD_CLEAR, 16'h20, CMD_NOP,  16'h0);
    k0   = mkCmd(16'd7,  CMD_NOP, 16'h0,  CMD_NOP, 16'h0,   CMD_SET,   16'h80);
    k2   = mkCmd(16'd7,  CMD_NOP, 16'h0,  CMD_NOP, 16'h0,   CMD_CLEAR, 16'h82);
    r0   = mkCmd(16'd9,  CMD_NOP, 16'h0,  CMD_SET, 16'h90,  CMD_NOP,   16'h0);

    // First grant from src0, then an idle cycle leaves the pointer at 1.
    vecs.push_back(mkVec(3'b001, cA, z, z, 1'b1, 3'b001, 1'b1, cA));
    vecs.push_back(mkVec(3'b000, z,  z, z, 1'b1, 3'b000, 1'b0, z));
    // Six-cycle rotation starting from pointer 1, including the wrap.
    vecs.push_back(mkVec(3'b111, c0, c1, c2, 1'b1, 3'b010, 1'b1, c1));
    vecs.push_back(mkVec(3'b111, c0, c1, c2, 1'b1, 3'b100, 1'b1, c2));
    vecs.push_back(mkVec(3'b111, c0, c1, c2, 1'b1, 3'b001, 1'b1, c0));
    vecs.push_back(mkVec(3'b111, c0, c1, c2, 1'b1, 3'b010, 1'b1, c1));
    vecs.push_back(mkVec(3'b111, c0, c1, c2, 1'b1, 3'b100, 1'b1, c2));
    vecs.push_back(mkVec(3'b111, c0, c1, c2, 1'b1, 3'b001, 1'b1, c0));
    // Backpressure for four cycles, then release with no bubble.
    for (int i = 0; i < 4; i++)
      vecs.push_back(mkVec(3'b111, c0, c1, c2, 1'b0, 3'b000, 1'b1, c0));
    vecs.push_back(mkVec(3'b111, c0, c1, c2, 1'b1, 3'b010, 1'b1, c1));
    vecs.push_back(mkVec(3'b000, z, z, z, 1'b1, 3'b000, 1'b0, z));
    // Same-flow, non-conflicting commands from src0 and src1 (pointer at 2).
`ifdef TX_SCHED_ARB_COALESCE_EN
    vecs.push_back(mkVec(3'b011, m0, m1, z, 1'b1, 3'b011, 1'b1, mAll));
    vecs.push_back(mkVec(3'b000, z,  z,  z, 1'b1, 3'b000, 1'b0, z));
`else
    vecs.push_back(mkVec(3'b011, m0, m1, z, 1'b1, 3'b001, 1'b1, m0));
    vecs.push_back(mkVec(3'b010, z,  m1, z, 1'b1, 3'b010, 1'b1, m1));
`endif
    // Move pointer to 0, then conflicting rt commands: src0 first, src2 next cycle.
    vecs.push_back(mkVec(3'b100, z,  z, dD, 1'b1, 3'b100, 1'b1, dD));
    vecs.push_back(mkVec(3'b101, k0, z, k2, 1'b1, 3'b001, 1'b1, k0));
    vecs.push_back(mkVec(3'b100, z,  z, k2, 1'b1, 3'b100, 1'b1, k2));

    rst_n    = 1'b0;
    srcVal   = 3'b111;
    srcData  = '0;
    schedRdy = 1'b1;
    #12;
    checkOutput("reset.src_rdy",  128'(srcRdy),  128'(3'b000));
    checkOutput("reset.out_val",  128'(outVal),  128'(1'b0));
    checkOutput("reset.out_data", 128'(outData), 128'(z));
    @(negedge clk);
    srcVal = 3'b000;
    rst_n  = 1'b1;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // Reset asserted while a command is held in the output stage.
    @(negedge clk);
    srcVal     = 3'b001;
    srcData[0] = r0;
    schedRdy   = 1'b0;
    #1;
    checkOutput("midrst.pre_val", 128'(outVal), 128'(1'b1));
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.out_val", 128'(outVal), 128'(1'b0));
    checkOutput("midrst.src_rdy", 128'(srcRdy), 128'(3'b000));
    @(negedge clk);
    rst_n    = 1'b1;
    srcVal   = 3'b000;
    schedRdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("midrst.noreplay%0d", i), 128'(outVal), 128'(1'b0));
    end
    // Pointer was cleared by reset: with src1 and src2 valid, src1 wins.
    @(negedge clk);
    srcVal     = 3'b110;
    srcData[1] = c1;
    srcData[2] = c2;
    #1;
    checkOutput("postrst.src_rdy", 128'(srcRdy), 128'(3'b010));
    @(posedge clk);
    #1;
    checkOutput("postrst.out_data", 128'(outData), 128'(c1));
    @(negedge clk);
    srcVal = 3'b000;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
